// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: owns the fetch PC, reads instruction memory and
// buffers {pc, instr, fault} in a small prefetch FIFO drained by decode.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] IMEM_WORDS = 32'd255
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        out_fault
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             fault_stop_q, fault_stop_d;

    logic [31:0]           pc_mem_q    [FIFO_DEPTH];
    logic [31:0]           instr_mem_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fault_mem_q;

    logic        in_range;
    logic        enq;
    logic        deq;
    logic [31:0] wr_instr;

    // Low address bits are dropped on redirect; kept here only to consume them.
    logic unused_redirect_lsb;
    assign unused_redirect_lsb = ^redirect_pc[1:0];

    assign imem_addr = fetch_pc_q;
    assign out_valid = (count_q != '0);
    assign out_pc    = pc_mem_q[rd_ptr_q];
    assign out_instr = instr_mem_q[rd_ptr_q];
    assign out_fault = fault_mem_q[rd_ptr_q];

    always_comb begin
        in_range     = ({2'b00, fetch_pc_q[31:2]} < IMEM_WORDS);
        deq          = out_valid && out_ready;
        enq          = !redirect_valid && !fault_stop_q && ((count_q < DEPTH_C) || deq);
        wr_instr     = in_range ? imem_data : NOP_INSTR;
        fetch_pc_d   = fetch_pc_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        fault_stop_d = fault_stop_q;

        if (redirect_valid) begin
            fetch_pc_d   = {redirect_pc[31:2], 2'b00};
            rd_ptr_d     = '0;
            wr_ptr_d     = '0;
            count_d      = '0;
            fault_stop_d = 1'b0;
        end else begin
            if (enq) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
                wr_ptr_d   = wr_ptr_q + PTR_W'(1);
                if (!in_range) begin
                    fault_stop_d = 1'b1;
                end
            end
            if (deq) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (enq && !deq) begin
                count_d = count_q + CNT_W'(1);
            end else if (!enq && deq) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q   <= RESET_PC;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            fault_stop_q <= 1'b0;
            fault_mem_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                pc_mem_q[i]    <= '0;
                instr_mem_q[i] <= '0;
            end
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            fault_stop_q <= fault_stop_d;
            // A full FIFO may be written while its head leaves in the same cycle.
            if (enq) begin
                pc_mem_q[wr_ptr_q]    <= fetch_pc_q;
                instr_mem_q[wr_ptr_q] <= wr_instr;
                fault_mem_q[wr_ptr_q] <= !in_range;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: three instances (default, 4-word and full-range memory)
// share stimulus; expected {pc, instr, fault} entries are queued and popped on handshakes.
module tb_fetch_unit;

  localparam logic [31:0] SALT = 32'h5A17_C3E9;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_ready = 1'b0;

  logic [31:0] a_addr, a_data, a_instr, a_pc;
  logic        a_v, a_fault;
  logic [31:0] b_addr, b_data, b_instr, b_pc;
  logic        b_v, b_fault;
  logic [31:0] c_addr, c_data, c_instr, c_pc;
  logic        c_v, c_fault;

  int          sel = 0;
  logic [31:0] o_addr, o_instr, o_pc;
  logic        o_v, o_fault;

  logic [64:0] exp_q[$];
  int          pass_cnt = 0;
  int          total_cnt = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a, input logic [31:0] s);
    return (a * 32'h9E37_79B1) ^ s;
  endfunction

  assign a_data = mem_word(a_addr, SALT);
  assign b_data = mem_word(b_addr, SALT);
  assign c_data = mem_word(c_addr, SALT);

  fetch_unit u_a (
    .clk(clk), .rst(rst), .imem_addr(a_addr), .imem_data(a_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(a_v), .out_ready(out_ready), .out_instr(a_instr),
    .out_pc(a_pc), .out_fault(a_fault)
  );

  fetch_unit #(.IMEM_WORDS(32'd4)) u_b (
    .clk(clk), .rst(rst), .imem_addr(b_addr), .imem_data(b_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(b_v), .out_ready(out_ready), .out_instr(b_instr),
    .out_pc(b_pc), .out_fault(b_fault)
  );

  fetch_unit #(.IMEM_WORDS(32'h4000_0000)) u_c (
    .clk(clk), .rst(rst), .imem_addr(c_addr), .imem_data(c_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(c_v), .out_ready(out_ready), .out_instr(c_instr),
    .out_pc(c_pc), .out_fault(c_fault)
  );

  always_comb begin
    o_addr = a_addr; o_v = a_v; o_instr = a_instr; o_pc = a_pc; o_fault = a_fault;
    case (sel)
      1: begin o_addr = b_addr; o_v = b_v; o_instr = b_instr; o_pc = b_pc; o_fault = b_fault; end
      2: begin o_addr = c_addr; o_v = c_v; o_instr = c_instr; o_pc = c_pc; o_fault = c_fault; end
      default: ;
    endcase
  end

  // Outputs are sampled at the negedge; inputs change there too.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [64:0] e;
    sel = 0;
    tick();
    total_cnt++;
    if ({o_v, o_addr, o_pc, o_instr, o_fault} !== {1'b0, 32'h0, 32'h0, 32'h0, 1'b0})
      $display("FAIL reset_state: got v=%b addr=%h pc=%h instr=%h fault=%b exp all 0",
               o_v, o_addr, o_pc, o_instr, o_fault);
    else pass_cnt++;
    rst = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    total_cnt++;
    if (o_v !== 1'b1 || o_addr !== 32'h8)
      $display("FAIL reset_prefill: got v=%b addr=%h exp v=1 addr=00000008", o_v, o_addr);
    else pass_cnt++;
    rst = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0100;
    tick();
    total_cnt++;
    if ({o_v, o_addr, o_pc, o_instr, o_fault} !== {1'b0, 32'h0, 32'h0, 32'h0, 1'b0})
      $display("FAIL reset_over_redirect: got v=%b addr=%h pc=%h instr=%h fault=%b exp all 0",
               o_v, o_addr, o_pc, o_instr, o_fault);
    else pass_cnt++;
    rst = 1'b0;
    redirect_valid = 1'b0;
    out_ready = 1'b1;
    exp_q.push_back({32'h0, mem_word(32'h0, SALT), 1'b0});
    exp_q.push_back({32'h4, mem_word(32'h4, SALT), 1'b0});
    for (int c = 0; c < 10 && exp_q.size() != 0; c++) begin
      if (o_v && out_ready) begin
        e = exp_q.pop_front();
        total_cnt++;
        if ({o_pc, o_instr, o_fault} !== e)
          $display("FAIL reset_resume: got %h/%h/%b exp %h/%h/%b",
                   o_pc, o_instr, o_fault, e[64:33], e[32:1], e[0]);
        else pass_cnt++;
      end
      tick();
    end
    total_cnt++;
    if (exp_q.size() != 0) begin
      $display("FAIL reset_resume_done: got %0d undelivered exp 0", exp_q.size());
      exp_q.delete();
    end else pass_cnt++;
  endtask

  task automatic test_stream();
    logic [64:0] e;
    int first_k;
    sel = 0;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++)
      exp_q.push_back({32'(i * 4), mem_word(32'(i * 4), SALT), 1'b0});
    first_k = -1;
    for (int k = 0; k < 6; k++) begin
      if (o_v && first_k < 0) first_k = k;
      if (o_v && out_ready && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        total_cnt++;
        if ({o_pc, o_instr, o_fault} !== e)
          $display("FAIL stream: got %h/%h/%b exp %h/%h/%b",
                   o_pc, o_instr, o_fault, e[64:33], e[32:1], e[0]);
        else pass_cnt++;
      end
      tick();
    end
    // k counts negedges after the last rst-high edge; the first fetch lands after edge 1.
    total_cnt++;
    if (first_k != 1) $display("FAIL stream_first_valid: got k=%0d exp k=1", first_k);
    else pass_cnt++;
    total_cnt++;
    if (exp_q.size() != 0) begin
      $display("FAIL stream_done: got %0d undelivered exp 0", exp_q.size());
      exp_q.delete();
    end else pass_cnt++;
  endtask

  task automatic test_backpressure();
    logic [64:0] e;
    sel = 0;
    do_reset();
    out_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k >= 3) begin
        total_cnt++;
        if (o_addr !== 32'h8 || o_v !== 1'b1 || o_pc !== 32'h0)
          $display("FAIL bp_hold k=%0d: got addr=%h v=%b pc=%h exp addr=00000008 v=1 pc=00000000",
                   k, o_addr, o_v, o_pc);
        else pass_cnt++;
      end
    end
    for (int i = 0; i < 3; i++)
      exp_q.push_back({32'(i * 4), mem_word(32'(i * 4), SALT), 1'b0});
    out_ready = 1'b1;
    for (int c = 0; c < 10 && exp_q.size() != 0; c++) begin
      if (o_v && out_ready) begin
        e = exp_q.pop_front();
        total_cnt++;
        if ({o_pc, o_instr, o_fault} !== e)
          $display("FAIL bp_drain: got %h/%h/%b exp %h/%h/%b",
                   o_pc, o_instr, o_fault, e[64:33], e[32:1], e[0]);
        else pass_cnt++;
      end
      tick();
    end
    total_cnt++;
    if (exp_q.size() != 0) begin
      $display("FAIL bp_done: got %0d undelivered exp 0", exp_q.size());
      exp_q.delete();
    end else pass_cnt++;
  endtask

  task automatic test_redirect();
    logic [64:0] e;
    sel = 0;
    do_reset();
    out_ready = 1'b0;
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0012;
    tick();
    redirect_valid = 1'b0;
    total_cnt++;
    if (o_v !== 1'b0 || o_addr !== 32'h10)
      $display("FAIL redir_flush: got v=%b addr=%h exp v=0 addr=00000010", o_v, o_addr);
    else pass_cnt++;
    exp_q.push_back({32'h10, mem_word(32'h10, SALT), 1'b0});
    exp_q.push_back({32'h14, mem_word(32'h14, SALT), 1'b0});
    out_ready = 1'b1;
    tick();
    total_cnt++;
    if (o_v !== 1'b1 || o_pc !== 32'h10)
      $display("FAIL redir_latency: got v=%b pc=%h exp v=1 pc=00000010", o_v, o_pc);
    else pass_cnt++;
    for (int c = 0; c < 10 && exp_q.size() != 0; c++) begin
      if (o_v && out_ready) begin
        e = exp_q.pop_front();
        total_cnt++;
        if ({o_pc, o_instr, o_fault} !== e)
          $display("FAIL redir_seq: got %h/%h/%b exp %h/%h/%b",
                   o_pc, o_instr, o_fault, e[64:33], e[32:1], e[0]);
        else pass_cnt++;
      end
      tick();
    end
    total_cnt++;
    if (exp_q.size() != 0) begin
      $display("FAIL redir_done: got %0d undelivered exp 0", exp_q.size());
      exp_q.delete();
    end else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [64:0] e;
    sel = 0;
    out_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0040;
    tick();
    redirect_pc = 32'h0000_0080;
    tick();
    redirect_valid = 1'b0;
    total_cnt++;
    if (o_v !== 1'b0 || o_addr !== 32'h80)
      $display("FAIL b2b_target: got v=%b addr=%h exp v=0 addr=00000080", o_v, o_addr);
    else pass_cnt++;
    for (int i = 0; i < 8; i++)
      exp_q.push_back({32'h80 + 32'(i * 4), mem_word(32'h80 + 32'(i * 4), SALT), 1'b0});
    for (int c = 0; c < 80 && exp_q.size() != 0; c++) begin
      out_ready = 1'($urandom_range(0, 1));
      if (o_v && out_ready) begin
        e = exp_q.pop_front();
        total_cnt++;
        if ({o_pc, o_instr, o_fault} !== e)
          $display("FAIL b2b_seq: got %h/%h/%b exp %h/%h/%b",
                   o_pc, o_instr, o_fault, e[64:33], e[32:1], e[0]);
        else pass_cnt++;
      end
      tick();
    end
    total_cnt++;
    if (exp_q.size() != 0) begin
      $display("FAIL b2b_done: got %0d undelivered exp 0", exp_q.size());
      exp_q.delete();
    end else pass_cnt++;
  endtask

  task automatic test_fault();
    logic [64:0] e;
    int valid_seen;
    sel = 1;
    out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0008;
    tick();
    redirect_valid = 1'b0;
    exp_q.push_back({32'h8, mem_word(32'h8, SALT), 1'b0});
    exp_q.push_back({32'hC, mem_word(32'hC, SALT), 1'b0});
    exp_q.push_back({32'h10, NOP, 1'b1});
    for (int c = 0; c < 10 && exp_q.size() != 0; c++) begin
      if (o_v && out_ready) begin
        e = exp_q.pop_front();
        total_cnt++;
        if ({o_pc, o_instr, o_fault} !== e)
          $display("FAIL fault_seq: got %h/%h/%b exp %h/%h/%b",
                   o_pc, o_instr, o_fault, e[64:33], e[32:1], e[0]);
        else pass_cnt++;
      end
      tick();
    end
    total_cnt++;
    if (exp_q.size() != 0) begin
      $display("FAIL fault_done: got %0d undelivered exp 0", exp_q.size());
      exp_q.delete();
    end else pass_cnt++;
    valid_seen = 0;
    for (int c = 0; c < 5; c++) begin
      if (o_v) valid_seen++;
      tick();
    end
    total_cnt++;
    if (valid_seen != 0 || o_addr !== 32'h14)
      $display("FAIL fault_stop: got valid_cycles=%0d addr=%h exp 0 and 00000014", valid_seen, o_addr);
    else pass_cnt++;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0000;
    tick();
    redirect_valid = 1'b0;
    exp_q.push_back({32'h0, mem_word(32'h0, SALT), 1'b0});
    exp_q.push_back({32'h4, mem_word(32'h4, SALT), 1'b0});
    for (int c = 0; c < 10 && exp_q.size() != 0; c++) begin
      if (o_v && out_ready) begin
        e = exp_q.pop_front();
        total_cnt++;
        if ({o_pc, o_instr, o_fault} !== e)
          $display("FAIL fault_resume: got %h/%h/%b exp %h/%h/%b",
                   o_pc, o_instr, o_fault, e[64:33], e[32:1], e[0]);
        else pass_cnt++;
      end
      tick();
    end
    total_cnt++;
    if (exp_q.size() != 0) begin
      $display("FAIL fault_resume_done: got %0d undelivered exp 0", exp_q.size());
      exp_q.delete();
    end else pass_cnt++;
  endtask

  task automatic test_wrap();
    logic [64:0] e;
    sel = 2;
    out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    exp_q.push_back({32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC, SALT), 1'b0});
    exp_q.push_back({32'h0, mem_word(32'h0, SALT), 1'b0});
    for (int c = 0; c < 10 && exp_q.size() != 0; c++) begin
      if (o_v && out_ready) begin
        e = exp_q.pop_front();
        total_cnt++;
        if ({o_pc, o_instr, o_fault} !== e)
          $display("FAIL wrap_seq: got %h/%h/%b exp %h/%h/%b",
                   o_pc, o_instr, o_fault, e[64:33], e[32:1], e[0]);
        else pass_cnt++;
      end
      tick();
    end
    total_cnt++;
    if (exp_q.size() != 0) begin
      $display("FAIL wrap_done: got %0d undelivered exp 0", exp_q.size());
      exp_q.delete();
    end else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_back_to_back();
    test_fault();
    test_wrap();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
